// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter with bounded lock in front of a single-port on-chip RAM.
// Read data is mirrored to both masters; only readdatavalid is steered via a latency pipeline.
module onchip_ram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BE_W       = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int unsigned CNT_W = 8;

    logic             last_grant_q, last_grant_d;
    logic             lock_valid_q, lock_valid_d;
    logic             lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [RD_LATENCY-1:0] rd_vld_q, rd_own_q;

    logic req0, req1, sel0, sel1, pick, lock_expired;
    logic accept, gnt_id, gnt_lock, gnt_write, gnt_read, other_req, rd_accept;
    logic [CNT_W-1:0] cnt_base;

    assign req0         = m0_read | m0_write;
    assign req1         = m1_read | m1_write;
    assign lock_expired = lock_valid_q && (lock_cnt_q >= CNT_W'(LOCK_MAX));

    // Selection: expired lock yields once, live lock keeps its owner, else round-robin
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        pick = ~last_grant_q;
        if (lock_expired) begin
            pick = ~lock_owner_q;
        end else if (lock_valid_q) begin
            pick = lock_owner_q;
        end
        if (!reset) begin
            if (req0 && req1) begin
                sel0 = ~pick;
                sel1 = pick;
            end else begin
                sel0 = req0;
                sel1 = req1;
            end
        end
    end

    assign accept    = sel0 | sel1;
    assign gnt_id    = sel1;
    assign gnt_lock  = sel1 ? m1_lock  : m0_lock;
    assign gnt_write = sel1 ? m1_write : m0_write;
    assign gnt_read  = sel1 ? m1_read  : m0_read;
    assign other_req = sel1 ? req0     : req1;
    assign rd_accept = accept & gnt_read & ~gnt_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            rd_vld_q     <= '0;
            rd_own_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_vld_q[0]  <= rd_accept;
            rd_own_q[0]  <= gnt_id;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_own_q[i] <= rd_own_q[i-1];
            end
        end
    end

    // Next-state: lock count only advances while the other master is actually waiting
    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        cnt_base     = '0;
        if (accept) begin
            last_grant_d = gnt_id;
            if (gnt_lock) begin
                if (lock_valid_q && (lock_owner_q == gnt_id)) begin
                    cnt_base = lock_cnt_q;
                end
                lock_valid_d = 1'b1;
                lock_owner_d = gnt_id;
                lock_cnt_d   = other_req ? cnt_base + CNT_W'(1) : cnt_base;
            end else begin
                lock_valid_d = 1'b0;
                lock_cnt_d   = '0;
            end
        end
    end

    // Outputs: RAM command follows the selected master, master 0 when idle
    always_comb begin
        m0_waitrequest   = reset | (req0 & ~sel0);
        m1_waitrequest   = reset | (req1 & ~sel1);
        ram_chipselect   = accept;
        ram_write        = accept & gnt_write;
        ram_address      = sel1 ? m1_address    : m0_address;
        ram_byteenable   = sel1 ? m1_byteenable : m0_byteenable;
        ram_writedata    = sel1 ? m1_writedata  : m0_writedata;
        ram_clken        = 1'b1;
        m0_readdata      = ram_readdata;
        m1_readdata      = ram_readdata;
        m0_readdatavalid = ~reset & rd_vld_q[RD_LATENCY-1] & ~rd_own_q[RD_LATENCY-1];
        m1_readdatavalid = ~reset & rd_vld_q[RD_LATENCY-1] &  rd_own_q[RD_LATENCY-1];
    end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural 1024x32 input-registered RAM.
module tb_onchip_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata, ram_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [1024];
    logic [9:0]  raddr;

    always #5 clk = ~clk;

    // RAM model: address/data registered on clk, unregistered q
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
            raddr <= ram_address;
        end
    end
    assign ram_readdata = mem[raddr];

    onchip_ram_arbiter #(.RD_LATENCY(1), .LOCK_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Inputs change 1 time unit after posedge, outputs are checked 1 unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    task automatic m0_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        m0_write = 1; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic rst_pulse();
        idle();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        m0_read = 1; m1_read = 1;
        #1;
        n_checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL reset_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
        n_checks++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin n_fail++;
            $display("FAIL reset_cs: got cs=%b wr=%b want 0 0", ram_chipselect, ram_write); end
        n_checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        n_checks++; if (ram_clken !== 1'b1) begin n_fail++;
            $display("FAIL clken: got %b want 1", ram_clken); end
        cyc(); cyc();
        reset = 0;
        idle();
    endtask

    task automatic test_single_write_read();
        m0_wr(10'h005, 32'hDEADBEEF, 4'hF);
        #1;
        n_checks++; if (m0_waitrequest !== 1'b0 || ram_chipselect !== 1'b1 || ram_write !== 1'b1) begin n_fail++;
            $display("FAIL single_wr: got wait=%b cs=%b wr=%b want 0 1 1", m0_waitrequest, ram_chipselect, ram_write); end
        cyc();
        idle(); m0_read = 1; m0_address = 10'h005;
        #1;
        n_checks++; if (m0_waitrequest !== 1'b0 || ram_write !== 1'b0 || ram_address !== 10'h005) begin n_fail++;
            $display("FAIL single_rd_cmd: got wait=%b wr=%b addr=%h want 0 0 005", m0_waitrequest, ram_write, ram_address); end
        cyc();
        idle();
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL single_rd_data: got v=%b d=%h want 1 deadbeef", m0_readdatavalid, m0_readdata); end
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL single_m1_rdv: got %b want 0", m1_readdatavalid); end
        cyc();
        n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL single_rdv_pulse: got %b want 0", m0_readdatavalid); end
    endtask

    task automatic test_alternate();
        logic exp_w0, exp_v0, exp_v1;
        logic [31:0] exp_d;
        m0_wr(10'h010, 32'hA0A00010, 4'hF); cyc();
        m0_wr(10'h020, 32'hB1B10020, 4'hF); cyc();
        rst_pulse();
        m0_read = 1; m0_address = 10'h010;
        m1_read = 1; m1_address = 10'h020;
        for (int i = 0; i < 7; i++) begin
            #1;
            exp_w0 = (i % 2 == 1);
            exp_v0 = (i > 0) && ((i - 1) % 2 == 0);
            exp_v1 = (i > 0) && ((i - 1) % 2 == 1);
            exp_d  = exp_v0 ? 32'hA0A00010 : 32'hB1B10020;
            if (i < 6) begin
                n_checks++; if (m0_waitrequest !== exp_w0 || m1_waitrequest !== !exp_w0) begin n_fail++;
                    $display("FAIL alt_grant[%0d]: got wait=%b%b want %b%b", i, m0_waitrequest, m1_waitrequest, exp_w0, !exp_w0); end
            end
            n_checks++; if (m0_readdatavalid !== exp_v0 || m1_readdatavalid !== exp_v1) begin n_fail++;
                $display("FAIL alt_rdv[%0d]: got %b%b want %b%b", i, m0_readdatavalid, m1_readdatavalid, exp_v0, exp_v1); end
            if (exp_v0 || exp_v1) begin
                n_checks++; if ((exp_v0 ? m0_readdata : m1_readdata) !== exp_d) begin n_fail++;
                    $display("FAIL alt_data[%0d]: got %h want %h", i, exp_v0 ? m0_readdata : m1_readdata, exp_d); end
            end
            cyc();
            if (i == 5) idle();
        end
        idle();
    endtask

    task automatic test_byte_enable();
        m0_wr(10'h040, 32'h11223344, 4'hF); cyc();
        m0_wr(10'h040, 32'hAABBCCDD, 4'h5); cyc();
        idle(); m0_read = 1; m0_address = 10'h040; cyc();
        idle();
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h11BB33DD) begin n_fail++;
            $display("FAIL byte_enable: got v=%b d=%h want 1 11bb33dd", m0_readdatavalid, m0_readdata); end
        cyc();
    endtask

    task automatic test_lock();
        logic exp_g1;
        rst_pulse();
        m0_read = 1; m0_lock = 1; m0_address = 10'h010;
        m1_read = 1; m1_address = 10'h020;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_g1 = (i % 4 == 3);
            n_checks++; if (m0_waitrequest !== exp_g1 || m1_waitrequest !== !exp_g1) begin n_fail++;
                $display("FAIL lock_grant[%0d]: got wait=%b%b want %b%b", i, m0_waitrequest, m1_waitrequest, exp_g1, !exp_g1); end
            cyc();
        end
        idle();
        cyc();
    endtask

    task automatic test_rw_together();
        idle();
        m1_read = 1; m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'h5A5A5A5A; m1_byteenable = 4'hF;
        #1;
        n_checks++; if (m1_waitrequest !== 1'b0 || ram_write !== 1'b1 || ram_address !== 10'h3FF) begin n_fail++;
            $display("FAIL rw_cmd: got wait=%b wr=%b addr=%h want 0 1 3ff", m1_waitrequest, ram_write, ram_address); end
        cyc();
        idle(); m1_read = 1; m1_address = 10'h3FF;
        #1;
        n_checks++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL rw_no_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        cyc();
        idle();
        #1;
        n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h5A5A5A5A) begin n_fail++;
            $display("FAIL rw_readback: got v=%b d=%h want 1 5a5a5a5a", m1_readdatavalid, m1_readdata); end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        idle(); m0_read = 1; m0_address = 10'h005;
        #1;
        n_checks++; if (m0_waitrequest !== 1'b0) begin n_fail++;
            $display("FAIL midrd_accept: got %b want 0", m0_waitrequest); end
        cyc();
        reset = 1; m1_read = 1;
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL midrd_discard: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        n_checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || ram_chipselect !== 1'b0) begin n_fail++;
            $display("FAIL midrd_wait: got %b%b cs=%b want 11 0", m0_waitrequest, m1_waitrequest, ram_chipselect); end
        cyc();
        reset = 0;
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_fail++;
            $display("FAIL midrd_flush: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
        n_checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL midrd_first_contest: got %b%b want 01", m0_waitrequest, m1_waitrequest); end
        cyc();
        idle();
        cyc();
    endtask

    initial begin
        test_reset();
        cyc();
        test_single_write_read();
        test_alternate();
        test_byte_enable();
        test_lock();
        test_rw_together();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
